overlay_mac_acc_pipe: RTL and testbench
=======================================

Name: overlay_mac_acc_pipe

Overview:
- Parametrised successor to the 2x2 overlay MAC: LANES SIMD multiply lanes feeding per-lane accumulators with programmable accumulation length.
- Adds valid/ready flow control, a 3-stage pipeline with stall, and sticky per-lane overflow flags.
- Sits between the operand fetch logic and the overlay result bus. Replaces the fixed 32-bit mult+ALU pairing.

Parameters:
- DATA_W, 16, operand width per lane.
- LANES, 2, SIMD lane count (power of two, >=1).
- ACC_W, 40, accumulator width per lane (>= 2*DATA_W).
- CNT_W, 8, width of the accumulation-length field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = wide (lane 0 product, single LANES*ACC_W accumulator with cross-lane carry); 1 = SIMD (independent lanes).
- a  in  LANES*DATA_W  multiplicand lanes.
- b  in  LANES*DATA_W  multiplier lanes.
- a_sign  in  1  1 = a signed.
- b_sign  in  1  1 = b signed.
- acc_len  in  CNT_W  beats per group; 0 is treated as 1.
- clear  in  1  synchronous flush of pipeline, accumulators, counter and overflow flags.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- S_reg  out  LANES*ACC_W  group result.
- out_valid  out  1  S_reg holds a completed group.
- out_ready  in  1  consumer accepts S_reg.
- ovf  out  LANES  sticky per-lane overflow (in mode 0 only bit 0 is used).

Behaviour:
- Reset (reset=0, async): all pipeline registers, accumulators, beat counter, S_reg, out_valid, ovf are cleared to 0. in_ready reads 1 once reset deasserts.
- Advance condition: adv = !out_valid | out_ready. in_ready = adv. When adv=0, every stage holds its value.
- Pipeline stages:
  - S1: register a, b, signs, mode, and a first/last tag.
  - S2: multiply. Each lane produces a 2*DATA_W product, sign-extended per a_sign/b_sign.
  - S3: accumulate.
- Latency: 3 accepted-clock cycles from the last beat of a group to out_valid=1.
- Group control:
  - Beat counter starts at 0. The first accepted beat of a group latches acc_len (as len) and mode.
  - mode and acc_len changes mid-group are ignored.
  - The beat with counter==len-1 is tagged last. The counter then returns to 0.
- Accumulate on a first-tagged beat: acc = product (load; previous value discarded). Otherwise: acc += product.
- On a last-tagged beat reaching S3: S_reg <= new acc value and out_valid <= 1. A following group's first beat may enter S3 on the next cycle with no bubble.
- out_valid drops on the cycle out_ready=1 unless a new last beat completes in that same cycle; in that case out_valid stays 1 and S_reg updates.
- Arithmetic:
  - SIMD: lane i accumulates into bits [i*ACC_W +: ACC_W]; no carry crosses lanes.
  - Wide: lane 0 product is sign/zero-extended to LANES*ACC_W and added with a full carry chain; upper-lane a/b are ignored.
  - Wrap-around modulo the accumulator width. ovf[i] is set when the signed (either sign set) or unsigned add overflows. ovf holds until clear or reset.
- clear=1:
  - Next edge empties S1–S3, zeroes the accumulators, counter, ovf and out_valid.
  - The input beat offered in that cycle is dropped.
  - clear has priority over everything except reset.
- Reset mid-group: the partial group is discarded and no out_valid is produced.

Optional Feature:
- Macro OVERLAY_MAC_ACC_SAT_EN.
- Defined: on overflow the accumulator lane clamps to its max/min (signed: 2^(ACC_W-1)-1 / -2^(ACC_W-1); unsigned: all-ones / 0) and ovf is still set.
- Undefined: wrap-around as above. The saturation logic is absent.

Decomposition:
- Package overlay_mac_pkg: DATA_W/LANES/ACC_W defaults, MODE_WIDE=1'b0, MODE_SIMD=1'b1 constants, lane slice/extend functions.
- One sub-module: overlay_simd_mult (S2, LANES signed/unsigned multipliers, combinational); the accumulator/control stays in the top.

Test Plan:
- Reset then SIMD, signed, acc_len=1, a={16'd3,-16'sd2}, b={16'd4,16'd5} -> 3 cycles later out_valid=1, S_reg lanes {12,-10}, ovf=0.
- Wide mode, unsigned, acc_len=4, a=b=16'hFFFF each beat -> S_reg = 4*0xFFFE0001 = 0x3_FFF8_0004, one out_valid pulse.
- Back-to-back groups acc_len=2, in_valid continuous, out_ready=1 -> out_valid on every 2nd cycle with correct sums; no lost beats.
- out_ready=0 while out_valid=1 -> in_ready=0, S_reg stable for 5 cycles; release -> results resume, no data lost.
- Signed SIMD, ACC_W=33, accumulate 0x7FFF*0x7FFF repeatedly until overflow -> ovf[lane]=1 and wraps (clamps to 2^32-1 with OVERLAY_MAC_ACC_SAT_EN).
- clear asserted mid-group (beat 2 of 4) -> no out_valid; next group of 1 beat produces that beat's product alone.

Source files
------------

// File: rtl/overlay_mac_acc_pipe_pkg.sv
// Shared widths, mode encodings and lane slice/extend helpers for the overlay MAC pipeline.
// Helpers work on a fixed 256-bit carrier so callers with any parameterisation can size-cast the result.
package overlay_mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 2;
    localparam int ACC_W_DEF  = 40;
    localparam int CNT_W_DEF  = 8;

    localparam logic MODE_WIDE = 1'b0;
    localparam logic MODE_SIMD = 1'b1;

    localparam int MAX_W = 256;
    typedef logic [MAX_W-1:0] wide_t;

    function automatic wide_t lane_slice(input wide_t bus, input int lane, input int w);
        return (bus >> (lane * w)) & (~wide_t'(0) >> (MAX_W - w));
    endfunction

    function automatic wide_t sign_ext(input wide_t v, input int w, input logic sgn);
        wide_t r;
        logic  fill;
        fill = sgn & v[w-1];
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < w) ? v[i] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/overlay_mac_acc_pipe_if.sv
// Operand/result bundle between operand fetch, the MAC pipeline and the overlay result bus.
// master = producer/consumer side, slave = the MAC pipeline.
interface overlay_mac_acc_pipe_if
    import overlay_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic                      mode;
    logic [LANES*DATA_W-1:0]   a;
    logic [LANES*DATA_W-1:0]   b;
    logic                      a_sign;
    logic                      b_sign;
    logic [CNT_W-1:0]          acc_len;
    logic                      clear;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*ACC_W-1:0]    S_reg;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES-1:0]          ovf;

    modport master (
        output mode, a, b, a_sign, b_sign, acc_len, clear, in_valid, out_ready,
        input  in_ready, S_reg, out_valid, ovf
    );

    modport slave (
        input  mode, a, b, a_sign, b_sign, acc_len, clear, in_valid, out_ready,
        output in_ready, S_reg, out_valid, ovf
    );

endinterface

// File: rtl/overlay_mac_acc_pipe_mult.sv
// LANES parallel DATA_W x DATA_W multipliers, each operand optionally signed; purely combinational.
// Operands are extended to the product width so the truncated product is exact for every sign mix.
module overlay_simd_mult #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2
) (
    input  logic [LANES*DATA_W-1:0]   a_i,
    input  logic [LANES*DATA_W-1:0]   b_i,
    input  logic                      a_sign_i,
    input  logic                      b_sign_i,
    output logic [LANES*2*DATA_W-1:0] prod_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic [DATA_W-1:0]   a_l;
        logic [DATA_W-1:0]   b_l;
        logic [2*DATA_W-1:0] a_x;
        logic [2*DATA_W-1:0] b_x;

        assign a_l = a_i[i*DATA_W +: DATA_W];
        assign b_l = b_i[i*DATA_W +: DATA_W];
        assign a_x = {{DATA_W{a_sign_i & a_l[DATA_W-1]}}, a_l};
        assign b_x = {{DATA_W{b_sign_i & b_l[DATA_W-1]}}, b_l};
        assign prod_o[i*2*DATA_W +: 2*DATA_W] = a_x * b_x;
    end

endmodule

// File: rtl/overlay_mac_acc_pipe.sv
// SIMD/wide multiply-accumulate, 3 stages (operand reg, multiply, accumulate); result 3 cycles after last beat.
// Whole pipe stalls while an unconsumed result is held; OVERLAY_MAC_ACC_SAT_EN selects clamping over wrap.
module overlay_mac_acc_pipe
    import overlay_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    overlay_mac_acc_pipe_if.slave mac_if
);

    localparam int PW = 2 * DATA_W;
    localparam int WW = LANES * ACC_W;

    logic                    adv;
    logic                    take;
    logic [CNT_W-1:0]        cnt_q, cnt_d, len_q, len_d, cur_len;
    logic                    gmode_q, gmode_d, cur_mode;
    logic                    beat_first, beat_last;

    logic                    s1_vld_q, s1_as_q, s1_bs_q, s1_mode_q, s1_first_q, s1_last_q;
    logic [LANES*DATA_W-1:0] s1_a_q, s1_b_q;
    logic [LANES*PW-1:0]     prod;

    logic                    s2_vld_q, s2_sgn_q, s2_mode_q, s2_first_q, s2_last_q;
    logic [LANES*PW-1:0]     s2_prod_q;

    logic [WW-1:0]           acc_q, acc_d, sreg_q, sreg_d;
    logic [LANES-1:0]        ovf_q, ovf_d;
    logic                    ovld_q, ovld_d;
    logic [WW-1:0]           simd_acc, wide_acc;
    logic [LANES-1:0]        simd_ov;
    logic                    wide_ov;

    assign adv             = !ovld_q | mac_if.out_ready;
    assign take            = mac_if.in_valid & adv & !mac_if.clear;
    assign mac_if.in_ready = adv;
    assign mac_if.S_reg    = sreg_q;
    assign mac_if.out_valid = ovld_q;
    assign mac_if.ovf      = ovf_q;

    // Length and mode come from the live inputs only on a group's first beat.
    always_comb begin
        beat_first = (cnt_q == '0);
        cur_len    = beat_first ? ((mac_if.acc_len == '0) ? CNT_W'(1) : mac_if.acc_len) : len_q;
        cur_mode   = beat_first ? mac_if.mode : gmode_q;
        beat_last  = (cnt_q == cur_len - 1'b1);
        cnt_d      = cnt_q;
        len_d      = len_q;
        gmode_d    = gmode_q;
        if (mac_if.clear) begin
            cnt_d   = '0;
            len_d   = '0;
            gmode_d = 1'b0;
        end else if (take) begin
            len_d   = cur_len;
            gmode_d = cur_mode;
            cnt_d   = beat_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_vld_q <= 1'b0; s1_a_q <= '0; s1_b_q <= '0; s1_as_q <= 1'b0; s1_bs_q <= 1'b0;
            s1_mode_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
        end else if (mac_if.clear) begin
            s1_vld_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q   <= mac_if.in_valid;
            s1_a_q     <= mac_if.a;
            s1_b_q     <= mac_if.b;
            s1_as_q    <= mac_if.a_sign;
            s1_bs_q    <= mac_if.b_sign;
            s1_mode_q  <= cur_mode;
            s1_first_q <= beat_first;
            s1_last_q  <= beat_last;
        end
    end

    overlay_simd_mult #(.DATA_W(DATA_W), .LANES(LANES)) u_mult (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .a_sign_i (s1_as_q),
        .b_sign_i (s1_bs_q),
        .prod_o   (prod)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s2_vld_q <= 1'b0; s2_prod_q <= '0; s2_sgn_q <= 1'b0;
            s2_mode_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
        end else if (mac_if.clear) begin
            s2_vld_q <= 1'b0;
        end else if (adv) begin
            s2_vld_q   <= s1_vld_q;
            s2_prod_q  <= prod;
            s2_sgn_q   <= s1_as_q | s1_bs_q;
            s2_mode_q  <= s1_mode_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ACC_W-1:0] base, ext, sum, res;
        logic             cy, ov;

        assign base = s2_first_q ? '0 : acc_q[i*ACC_W +: ACC_W];
        assign ext  = ACC_W'(sign_ext(lane_slice(wide_t'(s2_prod_q), i, PW), PW, s2_sgn_q));
        assign {cy, sum} = {1'b0, base} + {1'b0, ext};
        assign ov   = s2_sgn_q ? ((base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1])) : cy;
`ifdef OVERLAY_MAC_ACC_SAT_EN
        assign res  = !ov      ? sum :
                      !s2_sgn_q ? {ACC_W{1'b1}} :
                      ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
        assign res  = sum;
`endif
        assign simd_acc[i*ACC_W +: ACC_W] = res;
        assign simd_ov[i] = ov;
    end

    // Wide mode: lane 0 product against the full-width accumulator, carry crossing lane boundaries.
    logic [WW-1:0] w_base, w_ext, w_sum;
    logic          w_cy;

    assign w_base = s2_first_q ? '0 : acc_q;
    assign w_ext  = WW'(sign_ext(lane_slice(wide_t'(s2_prod_q), 0, PW), PW, s2_sgn_q));
    assign {w_cy, w_sum} = {1'b0, w_base} + {1'b0, w_ext};
    assign wide_ov = s2_sgn_q ? ((w_base[WW-1] == w_ext[WW-1]) && (w_sum[WW-1] != w_base[WW-1])) : w_cy;
`ifdef OVERLAY_MAC_ACC_SAT_EN
    assign wide_acc = !wide_ov  ? w_sum :
                      !s2_sgn_q ? {WW{1'b1}} :
                      w_ext[WW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
`else
    assign wide_acc = w_sum;
`endif

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        sreg_d = sreg_q;
        ovld_d = ovld_q;
        if (mac_if.clear) begin
            acc_d  = '0;
            ovf_d  = '0;
            ovld_d = 1'b0;
        end else if (adv) begin
            ovld_d = s2_vld_q & s2_last_q;
            if (s2_vld_q) begin
                if (s2_mode_q == MODE_SIMD) begin
                    acc_d = simd_acc;
                    ovf_d = ovf_q | simd_ov;
                end else begin
                    acc_d = wide_acc;
                    ovf_d = ovf_q | LANES'(wide_ov);
                end
                if (s2_last_q) sreg_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            len_q   <= '0;
            gmode_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= '0;
            sreg_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gmode_q <= gmode_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            sreg_q  <= sreg_d;
            ovld_q  <= ovld_d;
        end
    end

endmodule

// File: tb/tb_overlay_mac_acc_pipe.sv
// Scoreboard bench for overlay_mac_acc_pipe: driver feeds a group-level arithmetic model, monitor checks results.
module tb_overlay_mac_acc_pipe;
    import overlay_mac_pkg::*;

    localparam int DW = 16;
    localparam int LN = 2;
    localparam int AW = 33;
    localparam int CW = 8;
    localparam int WW = LN * AW;

    typedef struct {
        logic [WW-1:0] s;
        logic [LN-1:0] o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];

    int            m_cnt = 0;
    int            m_len = 1;
    logic          m_mode = 1'b0;
    logic [WW-1:0] m_acc = '0;
    logic [LN-1:0] m_ovf = '0;

    always #5 clk = ~clk;

    overlay_mac_acc_pipe_if #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .CNT_W(CW)) mif ();

    overlay_mac_acc_pipe #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .mac_if   (mif.slave)
    );

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic longint prod_of(input logic [DW-1:0] x, input bit xs, input logic [DW-1:0] y, input bit ys);
        longint px, py;
        px = longint'(x);
        py = longint'(y);
        if (xs && x[DW-1]) px = px - (longint'(1) << DW);
        if (ys && y[DW-1]) py = py - (longint'(1) << DW);
        return px * py;
    endfunction

    // Treat the w-bit accumulator as a signed or unsigned integer, add, and range-check the true sum.
    task automatic madd(input logic [131:0] acc_in, input int w, input longint prod, input bit sgn,
                        output logic [131:0] res, output bit ov);
        logic signed [131:0] m, cur, p, s, lo, hi;
        m   = 132'sd1 <<< w;
        cur = $signed(acc_in & (m - 1));
        if (sgn && acc_in[w-1]) cur = cur - m;
        p   = prod;
        s   = cur + p;
        if (sgn) begin
            lo = -(m >>> 1);
            hi = (m >>> 1) - 1;
        end else begin
            lo = 0;
            hi = m - 1;
        end
        ov = (s < lo) || (s > hi);
`ifdef OVERLAY_MAC_ACC_SAT_EN
        if (s < lo) s = lo;
        else if (s > hi) s = hi;
`endif
        res = s & (m - 1);
    endtask

    task automatic model_beat(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, input bit as, input bit bs,
                              input bit md, input logic [CW-1:0] len);
        bit            first, sgn, ov;
        logic [131:0]  base, r;
        longint        p;
        first = (m_cnt == 0);
        if (first) begin
            m_len  = (len == 0) ? 1 : int'(len);
            m_mode = md;
        end
        sgn = as | bs;
        if (m_mode == MODE_SIMD) begin
            for (int i = 0; i < LN; i++) begin
                p    = prod_of(a[i*DW +: DW], as, b[i*DW +: DW], bs);
                base = first ? '0 : 132'(m_acc[i*AW +: AW]);
                madd(base, AW, p, sgn, r, ov);
                m_acc[i*AW +: AW] = r[AW-1:0];
                m_ovf[i] = m_ovf[i] | ov;
            end
        end else begin
            p    = prod_of(a[DW-1:0], as, b[DW-1:0], bs);
            base = first ? '0 : 132'(m_acc);
            madd(base, WW, p, sgn, r, ov);
            m_acc    = r[WW-1:0];
            m_ovf[0] = m_ovf[0] | ov;
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_q.push_back('{s: m_acc, o: m_ovf});
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_acc = '0;
        m_ovf = '0;
    endtask

    task automatic drive(input bit v, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, input bit as,
                         input bit bs, input bit md, input logic [CW-1:0] len, input bit clr, input bit ordy);
        @(negedge clk);
        mif.in_valid  = v;
        mif.a         = a;
        mif.b         = b;
        mif.a_sign    = as;
        mif.b_sign    = bs;
        mif.mode      = md;
        mif.acc_len   = len;
        mif.clear     = clr;
        mif.out_ready = ordy;
        #1;
        if (clr) model_reset();
        else if (v && mif.in_ready) model_beat(a, b, as, bs, md, len);
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, ordy);
    endtask

    task automatic rnd_beat(input bit md, input logic [CW-1:0] len, input bit ordy);
        drive(1'b1, LN*DW'($urandom), LN*DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              md, len, 1'b0, ordy);
    endtask

    // Returns cycles from the acceptance edge of the previous beat until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        #1;
        while (!mif.out_valid && lat < 12) begin
            idle(1'b1);
            #1;
            lat++;
        end
        total++;
        if (!mif.out_valid) begin
            bad++;
            $display("FAIL out_valid_timeout: got 0 want 1");
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && mif.out_valid && mif.out_ready) begin
                n_xfer++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got S_reg=%h ovf=%b want none", mif.S_reg, mif.ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (mif.S_reg !== e.s || mif.ovf !== e.o) begin
                        bad++;
                        $display("FAIL group_result: got S_reg=%h ovf=%b want S_reg=%h ovf=%b",
                                 mif.S_reg, mif.ovf, e.s, e.o);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            lat;
        int            x0;
        logic [WW-1:0] held;
        mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.a_sign = 1'b0; mif.b_sign = 1'b0;
        mif.mode = 1'b0; mif.acc_len = '0; mif.clear = 1'b0; mif.out_ready = 1'b1;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_out_valid", 132'(mif.out_valid), 132'(0));
        chk("reset_in_ready", 132'(mif.in_ready), 132'(1));
        chk("reset_S_reg", 132'(mif.S_reg), 132'(0));
        chk("reset_ovf", 132'(mif.ovf), 132'(0));

        drive(1'b1, {16'd3, 16'hFFFE}, {16'd4, 16'd5}, 1'b1, 1'b1, MODE_SIMD, 8'd1, 1'b0, 1'b1);
        wait_out(lat);
        chk("latency", 132'(lat), 132'(3));
        chk("simd_signed_S_reg", 132'(mif.S_reg), 132'({33'd12, 33'h1FFFFFFF6}));
        chk("simd_signed_ovf", 132'(mif.ovf), 132'(0));
        repeat (3) idle(1'b1);

        x0 = n_xfer;
        repeat (4) drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, MODE_WIDE, 8'd4, 1'b0, 1'b1);
        wait_out(lat);
        chk("wide_unsigned_S_reg", 132'(mif.S_reg), 132'(66'h3_FFF8_0004));
        repeat (5) idle(1'b1);
        chk("wide_single_pulse", 132'(n_xfer - x0), 132'(1));

        x0 = n_xfer;
        repeat (16) rnd_beat(MODE_SIMD, 8'd2, 1'b1);
        repeat (4) idle(1'b1);
        chk("back_to_back_groups", 132'(n_xfer - x0), 132'(8));

        repeat (3) rnd_beat(MODE_SIMD, 8'd1, 1'b0);
        held = exp_q[0].s;
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            #1;
            chk("stall_in_ready", 132'(mif.in_ready), 132'(0));
            chk("stall_S_reg", 132'(mif.S_reg), 132'(held));
        end
        x0 = n_xfer;
        repeat (6) idle(1'b1);
        chk("stall_release", 132'(n_xfer - x0), 132'(3));

        repeat (8) drive(1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 1'b1, 1'b1, MODE_SIMD, 8'd8, 1'b0, 1'b1);
        wait_out(lat);
        chk("overflow_flags", 132'(mif.ovf), 132'(2'b11));
`ifdef OVERLAY_MAC_ACC_SAT_EN
        chk("overflow_S_reg", 132'(mif.S_reg), 132'({2{33'h0_FFFF_FFFF}}));
`else
        chk("overflow_S_reg", 132'(mif.S_reg), 132'({2{33'h1_FFF8_0008}}));
`endif
        repeat (3) idle(1'b1);

        rnd_beat(MODE_SIMD, 8'd4, 1'b1);
        rnd_beat(MODE_SIMD, 8'd4, 1'b1);
        repeat (4) idle(1'b1);
        drive(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, MODE_SIMD, 8'd1, 1'b1, 1'b1);
        #1;
        chk("clear_ovf", 132'(mif.ovf), 132'(0));
        chk("clear_out_valid", 132'(mif.out_valid), 132'(0));
        rnd_beat(MODE_SIMD, 8'd1, 1'b1);
        wait_out(lat);
        repeat (3) idle(1'b1);

        rnd_beat(MODE_WIDE, 8'd3, 1'b1);
        rnd_beat(MODE_WIDE, 8'd3, 1'b1);
        #3 rst_n = 1'b0;
        model_reset();
        #10 rst_n = 1'b1;
        repeat (4) idle(1'b1);
        #1;
        chk("midgroup_reset_out_valid", 132'(mif.out_valid), 132'(0));
        chk("midgroup_reset_S_reg", 132'(mif.S_reg), 132'(0));

        for (int k = 0; k < 500; k++) begin
            drive(1'($urandom_range(0, 9) < 7), LN*DW'($urandom), LN*DW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  CW'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 9) < 7));
        end
        repeat (12) idle(1'b1);
        chk("scoreboard_drained", 132'(exp_q.size()), 132'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
